// File: rtl/letreiro_pkg.sv
// Shared constants for the marquee sequencer: symbol codes, message ROM, state codes.
package letreiro_pkg;

  localparam logic [2:0] ESPACO = 3'd0;
  localparam logic [2:0] G      = 3'd1;
  localparam logic [2:0] A      = 3'd2;
  localparam logic [2:0] B      = 3'd3;
  localparam logic [2:0] R      = 3'd4;
  localparam logic [2:0] I      = 3'd5;
  localparam logic [2:0] E      = 3'd6;
  localparam logic [2:0] L      = 3'd7;

  localparam int TAM_MSG = 8;

  localparam logic [2:0] MSG_ROM [TAM_MSG] = '{G, A, B, R, I, E, L, ESPACO};

  // Sequencer state codes
  localparam logic [1:0] PARADO  = 2'd0;
  localparam logic [1:0] ROLANDO = 2'd1;
  localparam logic [1:0] PAUSADO = 2'd2;

  typedef logic [1:0] estado_t;

endpackage

// File: rtl/letreiro_prescaler.sv
// Scroll-rate prescaler: counts 0..DIV-1 while enabled, ticks on the terminal count.
module letreiro_prescaler #(
  parameter int DIV = 50000000
) (
  input  logic clock,
  input  logic limpar,
  input  logic habilitar,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] conta;

  // Disabled means parked at zero, so re-enabling always starts a full interval.
  always_ff @(posedge clock) begin
    if (limpar || !habilitar) begin
      conta <= '0;
    end else if (conta == TERM) begin
      conta <= '0;
    end else begin
      conta <= conta + CW'(1);
    end
  end

  assign tick = habilitar && (conta == TERM);

endmodule

// File: rtl/letreiro_rolagem.sv
// Marquee sequencer: scrolls a NUM_DISP-wide window over the message ROM.
// Build option LETREIRO_DIRECAO_EN adds the direcao input for reverse scrolling.
//
//   state   | meaning
//   PARADO  | idle after reset/limpar, display blank
//   ROLANDO | scrolling, one step per DIV cycles
//   PAUSADO | paused, window held
module letreiro_rolagem
  import letreiro_pkg::*;
#(
  parameter int NUM_DISP = 4,
  parameter int MSG_LEN  = TAM_MSG,
  parameter int DIV      = 50000000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       habilitar,
  input  logic                       limpar,
`ifdef LETREIRO_DIRECAO_EN
  input  logic                       direcao,
`endif
  output logic [3*NUM_DISP-1:0]      codigos,
  output logic [$clog2(MSG_LEN)-1:0] posicao,
  output logic                       volta,
  output logic                       ativo
);

  localparam int PW = $clog2(MSG_LEN);

  estado_t              estado;
  estado_t              prox_estado;
  logic                 passo;
  logic                 vira;
  logic [PW-1:0]        prox_pos;
  logic [3*NUM_DISP-1:0] janela;
  logic                 limpa;

  assign limpa = reset || limpar;

  letreiro_prescaler #(.DIV(DIV)) u_prescaler (
    .clock     (clock),
    .limpar    (limpa),
    .habilitar (estado == ROLANDO),
    .tick      (passo)
  );

  always_comb begin
    prox_estado = estado;
    case (estado)
      PARADO:  if (habilitar)  prox_estado = ROLANDO;
      ROLANDO: if (!habilitar) prox_estado = PAUSADO;
      PAUSADO: if (habilitar)  prox_estado = ROLANDO;
      default: prox_estado = PARADO;
    endcase
  end

  always_comb begin
    prox_pos = posicao;
    vira     = 1'b0;
`ifdef LETREIRO_DIRECAO_EN
    if (direcao) begin
      if (posicao == '0) begin
        prox_pos = PW'(MSG_LEN - 1);
        vira     = 1'b1;
      end else begin
        prox_pos = posicao - PW'(1);
      end
    end else
`endif
    if (posicao == PW'(MSG_LEN - 1)) begin
      prox_pos = '0;
      vira     = 1'b1;
    end else begin
      prox_pos = posicao + PW'(1);
    end
  end

  // Wrap by compare-and-subtract; the sum never exceeds 2*MSG_LEN-2.
  for (genvar k = 0; k < NUM_DISP; k++) begin : g_slot
    logic [PW:0]   soma;
    logic [PW-1:0] idx;
    assign soma = {1'b0, posicao} + (PW+1)'(k);
    assign idx  = (soma >= (PW+1)'(MSG_LEN)) ? PW'(soma - (PW+1)'(MSG_LEN)) : PW'(soma);
    assign janela[3*k +: 3] = MSG_ROM[idx];
  end

  always_ff @(posedge clock) begin
    if (limpa) begin
      estado  <= PARADO;
      posicao <= '0;
      volta   <= 1'b0;
      ativo   <= 1'b0;
      codigos <= '0;
    end else begin
      estado  <= prox_estado;
      ativo   <= (prox_estado == ROLANDO);
      volta   <= passo && vira;
      if (passo) begin
        posicao <= prox_pos;
      end
      codigos <= (estado == PARADO) ? '0 : janela;
    end
  end

endmodule

// File: tb/tb_letreiro_rolagem.sv
// Bench for letreiro_rolagem: DIV=4 and DIV=1 instances checked against a cycle model via a queue.
module tb_letreiro_rolagem;

  logic        clock = 1'b0;
  logic        reset;
  logic        hab0, hab1, lim0, lim1, dir0, dir1;
  logic [11:0] cod0, cod1;
  logic [2:0]  pos0, pos1;
  logic        volta0, volta1, ativo0, ativo1;

  int n_chk = 0;
  int n_ok  = 0;

  typedef struct {
    logic [11:0] cod;
    logic [2:0]  pos;
    logic        volta;
    logic        ativo;
  } saida_t;

  saida_t fila[$];

  localparam bit [2:0] ROM_REF [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

  int          m_st  [2];
  int          m_pre [2];
  int          m_pos [2];
  logic        m_volta [2];
  logic        m_ativo [2];
  logic [11:0] m_cod [2];

  always #5 clock = ~clock;

  letreiro_rolagem #(.NUM_DISP(4), .MSG_LEN(8), .DIV(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .habilitar (hab0),
    .limpar    (lim0),
`ifdef LETREIRO_DIRECAO_EN
    .direcao   (dir0),
`endif
    .codigos   (cod0),
    .posicao   (pos0),
    .volta     (volta0),
    .ativo     (ativo0)
  );

  letreiro_rolagem #(.NUM_DISP(4), .MSG_LEN(8), .DIV(1)) dut1 (
    .clock     (clock),
    .reset     (reset),
    .habilitar (hab1),
    .limpar    (lim1),
`ifdef LETREIRO_DIRECAO_EN
    .direcao   (dir1),
`endif
    .codigos   (cod1),
    .posicao   (pos1),
    .volta     (volta1),
    .ativo     (ativo1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_ok++;
    else $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] janela_ref(input int p);
    logic [11:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[3*k +: 3] = ROM_REF[(p + k) % 8];
    return r;
  endfunction

  // Reference model: st 0=idle, 1=scrolling, 2=paused.
  task automatic modelo(input int i, input logic h, input logic l, input logic d, input int div);
    int ns;
    int np;
    bit step;
    bit wrapv;
    saida_t s;
    if (reset || l) begin
      m_st[i] = 0; m_pre[i] = 0; m_pos[i] = 0;
      m_volta[i] = 1'b0; m_ativo[i] = 1'b0; m_cod[i] = '0;
    end else begin
      step  = (m_st[i] == 1) && (m_pre[i] == div - 1);
      np    = m_pos[i];
      wrapv = 1'b0;
      if (step) begin
        if (d) begin
          np    = (m_pos[i] == 0) ? 7 : m_pos[i] - 1;
          wrapv = (m_pos[i] == 0);
        end else begin
          np    = (m_pos[i] + 1) % 8;
          wrapv = (np == 0);
        end
      end
      if (m_st[i] == 0) ns = h ? 1 : 0;
      else              ns = h ? 1 : 2;
      m_cod[i]   = (m_st[i] == 0) ? 12'h000 : janela_ref(m_pos[i]);
      m_pre[i]   = (ns == 1 && m_st[i] == 1 && !step) ? m_pre[i] + 1 : 0;
      m_volta[i] = step && wrapv;
      m_pos[i]   = np;
      m_ativo[i] = (ns == 1);
      m_st[i]    = ns;
    end
    s.cod = m_cod[i]; s.pos = 3'(m_pos[i]); s.volta = m_volta[i]; s.ativo = m_ativo[i];
    fila.push_back(s);
  endtask

  task automatic ciclo();
    saida_t e;
    modelo(0, hab0, lim0, dir0, 4);
    modelo(1, hab1, lim1, dir1, 1);
    @(posedge clock);
    #1;
    e = fila.pop_front();
    chk("d4_codigos", cod0, e.cod);
    chk("d4_posicao", pos0, e.pos);
    chk("d4_volta", volta0, e.volta);
    chk("d4_ativo", ativo0, e.ativo);
    e = fila.pop_front();
    chk("d1_codigos", cod1, e.cod);
    chk("d1_posicao", pos1, e.pos);
    chk("d1_volta", volta1, e.volta);
    chk("d1_ativo", ativo1, e.ativo);
  endtask

  task automatic espera_pos(input logic [2:0] alvo, input string tag);
    int n;
    n = 0;
    while (pos0 != alvo && n < 100) begin
      ciclo();
      n++;
    end
    chk(tag, pos0, alvo);
  endtask

  initial begin
    int n;
    reset = 1'b1; hab0 = 1'b0; hab1 = 1'b0; lim0 = 1'b0; lim1 = 1'b0; dir0 = 1'b0; dir1 = 1'b0;
    for (int j = 0; j < 2; j++) begin
      m_st[j] = 0; m_pre[j] = 0; m_pos[j] = 0;
      m_volta[j] = 1'b0; m_ativo[j] = 1'b0; m_cod[j] = '0;
    end
    @(negedge clock);
    ciclo();
    ciclo();
    chk("rst_codigos", cod0, 12'h000);
    chk("rst_posicao", pos0, 3'd0);
    chk("rst_volta", volta0, 1'b0);
    chk("rst_ativo", ativo0, 1'b0);

    // Start scrolling: window visible one cycle after entering ROLANDO
    reset = 1'b0; hab0 = 1'b1; hab1 = 1'b1;
    ciclo();
    chk("t1_ativo", ativo0, 1'b1);
    ciclo();
    chk("t1_janela0", cod0, 12'o4321);
    ciclo(); ciclo(); ciclo();
    chk("t1_posicao1", pos0, 3'd1);
    ciclo();
    chk("t1_janela1", cod0, 12'o5432);

    // Window wrap at posicao 6, one wrap per full lap
    espera_pos(3'd6, "t2_espera6");
    ciclo();
    chk("t2_janela6", cod0, 12'o2107);
    n = 0;
    for (int c = 0; c < 32; c++) begin
      ciclo();
      if (volta0) n++;
    end
    chk("t2_voltas", n, 1);

    // Pause at posicao 3, then resume
    espera_pos(3'd3, "t3_espera3");
    hab0 = 1'b0;
    ciclo();
    for (int c = 0; c < 20; c++) begin
      ciclo();
      chk("t3_pausa_pos", pos0, 3'd3);
      chk("t3_pausa_ativo", ativo0, 1'b0);
    end
    chk("t3_pausa_janela", cod0, 12'o7654);
    hab0 = 1'b1;
    n = 0;
    while (pos0 == 3'd3 && n < 20) begin
      ciclo();
      n++;
    end
    chk("t3_retomada", n, 5);

    // limpar mid-interval at posicao 5
    espera_pos(3'd5, "t4_espera5");
    ciclo();
    lim0 = 1'b1;
    ciclo();
    chk("t4_lim_codigos", cod0, 12'h000);
    chk("t4_lim_posicao", pos0, 3'd0);
    chk("t4_lim_ativo", ativo0, 1'b0);
    chk("t4_lim_volta", volta0, 1'b0);
    lim0 = 1'b0;

    // limpar on the 7->0 step cycle
    espera_pos(3'd7, "t4_espera7");
    ciclo(); ciclo(); ciclo();
    lim0 = 1'b1;
    ciclo();
    chk("t4_wrap_volta", volta0, 1'b0);
    chk("t4_wrap_posicao", pos0, 3'd0);
    chk("t4_wrap_ativo", ativo0, 1'b0);
    lim0 = 1'b0;

    // DIV=1: one step per cycle, one wrap per 8 cycles
    n = 0;
    for (int c = 0; c < 64; c++) begin
      ciclo();
      if (volta1) n++;
    end
    chk("t5_voltas", n, 8);

`ifdef LETREIRO_DIRECAO_EN
    lim0 = 1'b1;
    ciclo();
    lim0 = 1'b0; dir0 = 1'b1;
    ciclo(); ciclo(); ciclo(); ciclo(); ciclo();
    chk("t6_rev_posicao", pos0, 3'd7);
    chk("t6_rev_volta", volta0, 1'b1);
    ciclo();
    chk("t6_rev_janela", cod0, 12'o3210);
    dir0 = 1'b0;
    ciclo(); ciclo(); ciclo();
    chk("t6_fwd_posicao", pos0, 3'd0);
    chk("t6_fwd_volta", volta0, 1'b1);
    dir0 = 1'b1;
    ciclo();
    dir0 = 1'b0;
    ciclo(); ciclo(); ciclo();
    chk("t6_toggle_posicao", pos0, 3'd1);
`endif

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
